// File: rtl/hist_bin_feeder.sv
// Front end of the histogram RAM pipeline: bins a counted stream of samples
// into ADDR_W-bit addresses with a one-cycle ram_en strobe per sample.
module hist_bin_feeder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  sample_count,
  input  logic [DATA_W-1:0] bin_offset,
  input  logic [3:0]        bin_shift,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] addr_r,
  output logic              ram_en,
  output logic              busy,
  output logic              done,
  output logic [15:0]       underflow_cnt,
  output logic [15:0]       overflow_cnt
);

  localparam int unsigned      OOR_W   = 16;
  localparam logic [DATA_W-1:0] BIN_MAX = DATA_W'((2 ** ADDR_W) - 1);
  localparam logic [OOR_W-1:0]  OOR_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  remaining;
  logic [DATA_W-1:0] offset_q;
  logic [3:0]        shift_q;
  logic              drain_cnt;
  logic              s1_valid;
  logic [DATA_W:0]   s1_diff;

  logic              accept;
  logic [DATA_W-1:0] s1_q;
  logic              s1_neg;
  logic              s1_over;

  // Handshake and stage-2 bin decode from the registered difference
  always_comb begin
    accept  = in_valid && in_ready;
    s1_neg  = s1_diff[DATA_W];
    s1_q    = s1_diff[DATA_W-1:0] >> shift_q;
    s1_over = (s1_q > BIN_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      remaining     <= '0;
      offset_q      <= '0;
      shift_q       <= '0;
      drain_cnt     <= 1'b0;
      s1_valid      <= 1'b0;
      s1_diff       <= '0;
      in_ready      <= 1'b0;
      addr_r        <= '0;
      ram_en        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      underflow_cnt <= '0;
      overflow_cnt  <= '0;
    end else begin
      done <= 1'b0;

      // Stage 1: offset subtraction on accept
      s1_valid <= accept;
      if (accept) begin
        s1_diff <= {1'b0, in_data} - {1'b0, offset_q};
      end

      // Stage 2: address is forced to zero whenever no sample is present
      ram_en <= s1_valid;
      addr_r <= '0;
      if (s1_valid) begin
        if (s1_neg) begin
          addr_r <= '0;
          if (underflow_cnt != OOR_MAX) underflow_cnt <= underflow_cnt + OOR_W'(1);
        end else if (s1_over) begin
          addr_r <= ADDR_W'(BIN_MAX);
          if (overflow_cnt != OOR_MAX) overflow_cnt <= overflow_cnt + OOR_W'(1);
        end else begin
          addr_r <= s1_q[ADDR_W-1:0];
        end
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            remaining     <= sample_count;
            offset_q      <= bin_offset;
            shift_q       <= bin_shift;
            underflow_cnt <= '0;
            overflow_cnt  <= '0;
            busy          <= 1'b1;
            if (sample_count != '0) begin
              state    <= RUN;
              in_ready <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state     <= DRAIN;
              in_ready  <= 1'b0;
              drain_cnt <= 1'b0;
            end
          end
        end
        // Two cycles let the last sample leave stage 2 before done
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hist_bin_feeder.sv
// Bench for hist_bin_feeder: event-scheduled reference model checked every
// cycle, plus directed scenarios with literal expected bin sequences.
module tb_hist_bin_feeder;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  sample_count = '0;
  logic [DATA_W-1:0] bin_offset = '0;
  logic [3:0]        bin_shift = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] addr_r;
  logic              ram_en;
  logic              busy;
  logic              done;
  logic [15:0]       underflow_cnt;
  logic [15:0]       overflow_cnt;

  hist_bin_feeder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_count(sample_count),
    .bin_offset(bin_offset), .bin_shift(bin_shift), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .addr_r(addr_r), .ram_en(ram_en),
    .busy(busy), .done(done), .underflow_cnt(underflow_cnt),
    .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d", name, act, act, exp);
    end
  endtask

  function automatic void bin_of(input int d, input int off, input int sh,
                                 output int a, output bit u, output bit o);
    int q;
    u = 0; o = 0;
    if (d < off) begin
      a = 0; u = 1;
    end else begin
      q = (d - off) >> sh;
      if (q > 31) begin a = 31; o = 1; end
      else a = q;
    end
  endfunction

  // Reference model: expected outputs after each edge, scheduled by edge index
  int     cyc = 0;
  bit     chk_en = 0;
  bit     m_busy = 0, m_ready = 0, m_ram_en = 0, m_done = 0, pend = 0;
  int     m_addr = 0, m_uf = 0, m_of = 0, pend_data = 0, m_off = 0, m_sh = 0;
  longint m_rem = 0;
  int     done_edge = -1, idle_edge = -1;

  always @(posedge clk) begin
    bit was_busy, acc, u, o;
    int a;
    cyc++;
    if (rst) begin
      m_busy = 0; m_ready = 0; m_ram_en = 0; m_addr = 0; m_done = 0;
      m_uf = 0; m_of = 0; pend = 0; m_rem = 0; done_edge = -1; idle_edge = -1;
    end else begin
      was_busy = m_busy;
      m_ram_en = pend;
      m_addr   = 0;
      if (pend) begin
        bin_of(pend_data, m_off, m_sh, a, u, o);
        m_addr = a;
        if (u && m_uf < 65535) m_uf++;
        if (o && m_of < 65535) m_of++;
      end
      acc       = in_valid && m_ready;
      pend      = acc;
      pend_data = int'(in_data);
      m_done    = (cyc == done_edge);
      if (cyc == idle_edge) m_busy = 0;
      if (acc) begin
        m_rem--;
        if (m_rem == 0) begin
          m_ready = 0; done_edge = cyc + 2; idle_edge = cyc + 3;
        end
      end else if (!was_busy && start) begin
        m_off = int'(bin_offset); m_sh = int'(bin_shift);
        m_uf = 0; m_of = 0; m_busy = 1;
        m_rem = longint'(sample_count);
        if (m_rem == 0) begin
          m_done = 1; done_edge = cyc; idle_edge = cyc + 1;
        end else begin
          m_ready = 1;
        end
      end
    end
    chk_en = 1;
  end

  // Per-cycle comparison and observation log
  int obs[$];
  bit en_trace[$];
  int done_seen = 0, done_cyc = 0, last_ram_cyc = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(m_ready));
      check("ram_en", 32'(ram_en), 32'(m_ram_en));
      check("addr_r", 32'(addr_r), 32'(m_addr));
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("underflow_cnt", 32'(underflow_cnt), 32'(m_uf));
      check("overflow_cnt", 32'(overflow_cnt), 32'(m_of));
      en_trace.push_back(ram_en === 1'b1);
      if (ram_en === 1'b1) begin
        obs.push_back(int'(addr_r));
        last_ram_cyc = cyc;
      end
      if (done === 1'b1) begin
        done_seen++;
        done_cyc = cyc;
      end
    end
  end

  task automatic step(bit st, bit v, int d);
    @(negedge clk);
    start    = st;
    in_valid = v;
    in_data  = DATA_W'(d);
  endtask

  task automatic cfg(int n, int off, int sh);
    sample_count = CNT_W'(n);
    bin_offset   = DATA_W'(off);
    bin_shift    = 4'(sh);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      step(0, 0, 0);
      n++;
    end while ((busy !== 1'b0 || m_busy) && n < 200);
    if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
    step(0, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic clear_log();
    obs.delete();
    en_trace.delete();
    done_seen = 0;
  endtask

  initial begin
    bit pat[7];
    int first;

    // Reset held with in_valid high
    rst = 1'b1;
    step(0, 1, 5);
    step(0, 1, 5);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_ram_en", 32'(ram_en), 32'd0);
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    step(0, 0, 0);

    // Basic binning
    clear_log();
    cfg(3, 0, 0);
    step(1, 0, 0);
    step(0, 1, 1); step(0, 1, 5); step(0, 1, 5);
    wait_idle();
    check("basic_count", 32'(obs.size()), 32'd3);
    if (obs.size() == 3) begin
      check("basic_a0", 32'(obs[0]), 32'd1);
      check("basic_a1", 32'(obs[1]), 32'd5);
      check("basic_a2", 32'(obs[2]), 32'd5);
    end
    check("basic_done_once", 32'(done_seen), 32'd1);
    check("basic_done_after_last", 32'(done_cyc), 32'(last_ram_cyc + 1));

    // Range handling
    clear_log();
    cfg(4, 100, 2);
    step(1, 0, 0);
    step(0, 1, 99); step(0, 1, 100); step(0, 1, 227); step(0, 1, 228);
    wait_idle();
    check("range_count", 32'(obs.size()), 32'd4);
    if (obs.size() == 4) begin
      check("range_a0", 32'(obs[0]), 32'd0);
      check("range_a1", 32'(obs[1]), 32'd0);
      check("range_a2", 32'(obs[2]), 32'd31);
      check("range_a3", 32'(obs[3]), 32'd31);
    end
    check("range_uf", 32'(underflow_cnt), 32'd1);
    check("range_of", 32'(overflow_cnt), 32'd1);

    // Handshake gaps, then an extra valid sample that must not be consumed
    clear_log();
    pat = '{1, 0, 0, 1, 1, 0, 1};
    cfg(4, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, pat[i], i + 3);
    step(0, 1, 30);
    step(0, 1, 31);
    wait_idle();
    check("gap_count", 32'(obs.size()), 32'd4);
    first = -1;
    foreach (en_trace[i]) if (first < 0 && en_trace[i]) first = i;
    if (first >= 0 && first + 7 <= en_trace.size()) begin
      for (int i = 0; i < 7; i++) check("gap_pattern", 32'(en_trace[first + i]), 32'(pat[i]));
    end else begin
      check("gap_trace_len", 32'(en_trace.size()), 32'(first + 7));
    end

    // Zero count
    clear_log();
    cfg(0, 0, 0);
    step(1, 0, 0);
    wait_idle();
    check("zero_done", 32'(done_seen), 32'd1);
    check("zero_no_ram_en", 32'(obs.size()), 32'd0);

    // Start during RUN is ignored
    clear_log();
    cfg(5, 10, 0);
    step(1, 0, 0);
    step(0, 1, 3); step(0, 1, 50);
    cfg(1, 0, 0);
    step(1, 1, 5);
    step(0, 1, 20); step(0, 1, 12);
    wait_idle();
    check("ign_count", 32'(obs.size()), 32'd5);
    if (obs.size() == 5) begin
      check("ign_a1", 32'(obs[1]), 32'd31);
      check("ign_a3", 32'(obs[3]), 32'd10);
      check("ign_a4", 32'(obs[4]), 32'd2);
    end
    check("ign_uf", 32'(underflow_cnt), 32'd2);
    check("ign_of", 32'(overflow_cnt), 32'd1);

    // Reset one cycle after an accept
    clear_log();
    cfg(3, 50, 0);
    step(1, 0, 0);
    step(0, 1, 10); step(0, 1, 20);
    @(negedge clk); rst = 1'b1; in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    check("rst_ram_en_count", 32'(obs.size()), 32'd1);
    check("rst_no_done", 32'(done_seen), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_uf", 32'(underflow_cnt), 32'd0);

    // Randomized traffic with stray starts and occasional resets
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 299) == 0);
      start        = ($urandom_range(0, 24) == 0);
      sample_count = CNT_W'($urandom_range(0, 12));
      bin_offset   = DATA_W'($urandom_range(0, 1200));
      bin_shift    = 4'($urandom_range(0, 6));
      in_valid     = ($urandom_range(0, 9) < 7);
      in_data      = DATA_W'($urandom_range(0, 3000));
    end
    @(negedge clk); rst = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hist_bin_feeder.md
# hist_bin_feeder

Upstream stage of the histogram RAM pipeline: accepts a stream of raw samples over a valid/ready handshake and converts each into a 5-bit bin address. Each address is issued with a single-cycle `ram_en` strobe to the histogram RAM's `addr_r`/`ram_en` inputs. The block runs one acquisition of a programmed number of samples, counts out-of-range samples, and signals completion. The histogram RAM accepts one increment per cycle, including back-to-back repeats of the same address, so this block has no downstream back-pressure.

## Interface
- `DATA_W`, 16, sample width (unsigned)
- `ADDR_W`, 5, bin address width; must match the histogram RAM
- `CNT_W`, 32, sample-count width
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle pulse; begins an acquisition, honoured only in IDLE
- `sample_count`  in  CNT_W  number of samples to bin; latched on `start`
- `bin_offset`  in  DATA_W  subtracted from each sample; latched on `start`
- `bin_shift`  in  4  right-shift applied after offset, range 0..15; latched on `start`
- `in_data`  in  DATA_W  sample
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  block accepts `in_data` this cycle
- `addr_r`  out  ADDR_W  bin address to the histogram RAM
- `ram_en`  out  1  increment strobe to the histogram RAM
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse at acquisition end
- `underflow_cnt`  out  16  samples below `bin_offset`, saturating
- `overflow_cnt`  out  16  samples whose bin exceeds 2^ADDR_W-1, saturating

## Operation
- The FSM has four states: IDLE, RUN, DRAIN and DONE.
- IDLE:
  - `in_ready`=0.
  - On `start`, latch `sample_count`, `bin_offset` and `bin_shift` into the config/remaining registers, and clear both out-of-range counters.
  - Go to RUN if `sample_count`!=0, else go to DONE.
- RUN:
  - `in_ready`=1.
  - An accept is `in_valid && in_ready`. Each accept decrements `remaining`.
  - The accept that takes `remaining` to 0 moves the FSM to DRAIN.
- DRAIN:
  - `in_ready`=0.
  - Wait exactly 2 cycles for the pipeline to empty, then go to DONE.
- DONE:
  - `done`=1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored.
- Pipeline stage 1, registered on accept:
  - `diff` = {1'b0,`in_data`} − {1'b0,`bin_offset`}, DATA_W+1 bits, signed.
  - Stage-1 valid flag set.
- Pipeline stage 2, registered from stage 1, drives the outputs:
  - If `diff`<0: `addr_r`=0 and `underflow_cnt`++.
  - Otherwise q = `diff` >> `bin_shift` (logical shift).
    - If q > 2^ADDR_W-1: `addr_r`=2^ADDR_W-1 and `overflow_cnt`++.
    - Else `addr_r`=q[ADDR_W-1:0].
  - `ram_en`=1.
- When stage 2 has no valid sample:
  - `ram_en`=0 and `addr_r`=0.
  - `addr_r` is never left at a stale value.
- Counters saturate at 16'hFFFF and hold until the next honoured `start`. They are readable at any time.
- Back-to-back accepts produce back-to-back `ram_en` cycles, and identical addresses may repeat.

## Timing
- Reset values:
  - State is IDLE.
  - Outputs: `in_ready`=0, `addr_r`=0, `ram_en`=0, `busy`=0, `done`=0, `underflow_cnt`=0, `overflow_cnt`=0.
  - Internal: both pipeline valid flags cleared, `remaining`=0.
- Latency:
  - A sample accepted at edge k is presented on `addr_r`/`ram_en` from edge k+1 to edge k+2. This is exactly one cycle of `ram_en` per sample.
  - The out-of-range counters update at the same edge k+1.
- `start` is sampled at edge s. `busy` is high from edge s. In RUN, `in_ready` is high from edge s.
- Last accept at edge k:
  - Its `ram_en` cycle runs from edge k+1 to edge k+2.
  - `done` is high from edge k+2 to edge k+3, i.e. in the cycle immediately after the last `ram_en` cycle.
  - `busy` falls at edge k+3.
- `sample_count`=0: state is DONE from edge s, `done` is high in the cycle after s, and `ram_en` is never asserted.
- `rst` mid-acquisition:
  - The next edge returns every register to its reset value.
  - In-flight samples are discarded with no `ram_en`, and no `done` pulse is produced.
- An `in_valid` gap of n cycles produces an n-cycle `ram_en`=0 / `addr_r`=0 bubble at the output, shifted by 1 cycle.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid`=1 → all outputs 0, `in_ready`=0, no `ram_en`.
- Basic binning:
  - Stimulus: `start` with `sample_count`=3, `bin_offset`=0, `bin_shift`=0; samples 1, 5, 5 accepted on consecutive edges k..k+2.
  - Response: `ram_en` high for 3 consecutive cycles with `addr_r`=1, 5, 5 starting at k+1; `done` in the cycle after; `busy` low one cycle later.
- Range handling:
  - Stimulus: `bin_offset`=100, `bin_shift`=2, samples 99, 100, 227, 228.
  - Response: `addr_r`=0, 0, 31, 31; `underflow_cnt`=1, `overflow_cnt`=1.
- Handshake gaps:
  - Stimulus: `sample_count`=4, `in_valid` pattern 1,0,0,1,1,0,1.
  - Response: `ram_en` pattern (delayed 1 cycle) 1,0,0,1,1,0,1 with `addr_r`=0 in the bubbles; `in_ready` drops after the 4th accept; a 5th valid sample is not consumed.
- Zero count and ignored start:
  - `sample_count`=0 → `done` the cycle after `start`, no `ram_en`.
  - A second `start` during RUN does not reload `remaining` and does not clear the counters.
- Reset mid-run:
  - Stimulus: assert `rst` one cycle after an accept.
  - Response: no `ram_en` for that sample, no `done`, state IDLE, counters 0.
